// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared definitions for the 16-bit CPU control path: FSM state
//            encodings, opcode/opext constants, condition codes, write-back
//            select encodings and the instruction-class decode helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // FSM states; 3-bit encoding leaves codes 4-7 unused (recovered to FETCH)
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_LOADWB = 3'd3
    } state_t;

    // Major opcodes (ir[15:12])
    localparam logic [3:0] c_OP_EXT   = 4'b0100;
    localparam logic [3:0] c_OP_BCOND = 4'b1100;
    localparam logic [3:0] c_OP_MOVI  = 4'b1101;
    localparam logic [3:0] c_OP_REG   = 4'b0000;

    // Extended opcodes (ir[7:4])
    localparam logic [3:0] c_OPX_LOAD  = 4'b0000;
    localparam logic [3:0] c_OPX_STOR  = 4'b0100;
    localparam logic [3:0] c_OPX_JAL   = 4'b1000;
    localparam logic [3:0] c_OPX_JCOND = 4'b1100;
    localparam logic [3:0] c_OPX_MOV   = 4'b1101;

    // Condition codes (ir[11:8])
    localparam logic [3:0] c_CC_EQ = 4'b0000;
    localparam logic [3:0] c_CC_NE = 4'b0001;
    localparam logic [3:0] c_CC_CS = 4'b0010;
    localparam logic [3:0] c_CC_CC = 4'b0011;
    localparam logic [3:0] c_CC_HI = 4'b0100;
    localparam logic [3:0] c_CC_LS = 4'b0101;
    localparam logic [3:0] c_CC_GT = 4'b0110;
    localparam logic [3:0] c_CC_LE = 4'b0111;
    localparam logic [3:0] c_CC_FS = 4'b1000;
    localparam logic [3:0] c_CC_FC = 4'b1001;
    localparam logic [3:0] c_CC_LO = 4'b1010;
    localparam logic [3:0] c_CC_HS = 4'b1011;
    localparam logic [3:0] c_CC_LT = 4'b1100;
    localparam logic [3:0] c_CC_GE = 4'b1101;
    localparam logic [3:0] c_CC_UC = 4'b1110;

    // Write-back source select
    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_MEM = 2'd1;
    localparam logic [1:0] c_WB_PC1 = 2'd2;

    typedef enum logic [2:0] {
        I_ALU   = 3'd0,
        I_BCOND = 3'd1,
        I_JCOND = 3'd2,
        I_LOAD  = 3'd3,
        I_STOR  = 3'd4,
        I_JAL   = 3'd5
    } iclass_t;

    // Anything not explicitly recognised falls into the ALU class.
    function automatic iclass_t decode_class(input logic [15:0] instr);
        iclass_t cls;
        cls = I_ALU;
        if (instr[15:12] == c_OP_BCOND) begin
            cls = I_BCOND;
        end else if (instr[15:12] == c_OP_EXT) begin
            case (instr[7:4])
                c_OPX_LOAD:  cls = I_LOAD;
                c_OPX_STOR:  cls = I_STOR;
                c_OPX_JAL:   cls = I_JAL;
                c_OPX_JCOND: cls = I_JCOND;
                default:     cls = I_ALU;
            endcase
        end
        return cls;
    endfunction

    // Moves write a register but leave the flags alone.
    function automatic logic is_move(input logic [15:0] instr);
        return (instr[15:12] == c_OP_MOVI) ||
               ((instr[15:12] == c_OP_REG) && (instr[7:4] == c_OPX_MOV));
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_controller_if.sv
// ============================================================================
// Module   : cpu_controller_if
// Purpose  : Bundles the controller's memory/flag inputs and its PC, memory,
//            register-file and PSR control outputs.
//            master : controller side (drives ir and strobes)
//            slave  : datapath side (drives mem_dout and flags)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_controller_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] mem_dout;
    logic [4:0]        flags;     // {C,L,F,Z,N}
    logic [DATA_W-1:0] ir;
    logic              pc_en;
    logic              pc_branch;
    logic              pc_jump;
    logic              addr_sel;
    logic              mem_we;
    logic              reg_we;
    logic [1:0]        wb_sel;
    logic              psr_we;
    logic [2:0]        state_o;

    modport master (
        input  mem_dout, flags,
        output ir, pc_en, pc_branch, pc_jump, addr_sel,
               mem_we, reg_we, wb_sel, psr_we, state_o
    );

    modport slave (
        output mem_dout, flags,
        input  ir, pc_en, pc_branch, pc_jump, addr_sel,
               mem_we, reg_we, wb_sel, psr_we, state_o
    );
endinterface

`default_nettype wire

// File: rtl/cond_eval.sv
// ============================================================================
// Module   : cond_eval
// Purpose  : Combinational branch/jump condition evaluation.
// Ports    : i_cond  [3:0] condition code (ir[11:8])
//            i_flags [4:0] PSR flags {C,L,F,Z,N}
//            o_taken       condition is true
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [4:0] i_flags,
    output logic       o_taken
);

    logic w_c, w_l, w_f, w_z, w_n;

    assign {w_c, w_l, w_f, w_z, w_n} = i_flags;

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            c_CC_EQ: o_taken = w_z;
            c_CC_NE: o_taken = ~w_z;
            c_CC_CS: o_taken = w_c;
            c_CC_CC: o_taken = ~w_c;
            c_CC_HI: o_taken = w_l;
            c_CC_LS: o_taken = ~w_l;
            c_CC_GT: o_taken = w_n;
            c_CC_LE: o_taken = ~w_n;
            c_CC_FS: o_taken = w_f;
            c_CC_FC: o_taken = ~w_f;
            c_CC_LO: o_taken = ~w_l & ~w_z;
            c_CC_HS: o_taken = w_l | w_z;
            c_CC_LT: o_taken = ~w_n & ~w_z;
            c_CC_GE: o_taken = w_n | w_z;
            c_CC_UC: o_taken = 1'b1;
            default: o_taken = 1'b0;     // 1111: never
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_controller.sv
// ============================================================================
// Module   : cpu_controller
// Purpose  : Multicycle sequencing FSM for the 16-bit CPU. Latches IR from
//            program memory and issues PC, memory, register-file and PSR
//            strobes. 3 cycles per instruction, 4 for LOAD.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous, active-high
//            bus   - cpu_controller_if.master (mem_dout, flags in; ir,
//                    pc_en, pc_branch, pc_jump, addr_sel, mem_we, reg_we,
//                    wb_sel, psr_we, state_o out)
// Options  : CTRL_JAL_EN - enables jump-and-link; otherwise JAL is a NOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_controller
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
)(
    input  logic               clk,
    input  logic               reset,
    cpu_controller_if.master   bus
);

    // The PC datapath sign-extends an 8-bit displacement to ADDR_W.
    if (ADDR_W < 8) begin : g_addr_w_check
        $error("cpu_controller: ADDR_W must be at least 8");
    end

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_ir;
    logic [15:0]       w_instr;
    iclass_t           w_class;
    logic              w_taken;

    assign w_instr = r_ir[15:0];
    assign w_class = decode_class(w_instr);

    cond_eval u_cond_eval (
        .i_cond  (w_instr[11:8]),
        .i_flags (bus.flags),
        .o_taken (w_taken)
    );

    // State and IR registers. IR only loads at the edge ending DECODE, when
    // the synchronous memory has returned the word addressed in FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_ir <= bus.mem_dout;
            end
        end
    end

    always_comb begin
        w_next        = S_FETCH;
        bus.pc_en     = 1'b0;
        bus.pc_branch = 1'b0;
        bus.pc_jump   = 1'b0;
        bus.addr_sel  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.reg_we    = 1'b0;
        bus.wb_sel    = c_WB_ALU;
        bus.psr_we    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_class)
                    I_BCOND: begin
                        bus.pc_en     = 1'b1;
                        bus.pc_branch = w_taken;
                    end
                    I_JCOND: begin
                        bus.pc_en   = 1'b1;
                        bus.pc_jump = w_taken;
                    end
                    I_STOR: begin
                        bus.addr_sel = 1'b1;
                        bus.mem_we   = 1'b1;
                        bus.pc_en    = 1'b1;
                    end
                    I_LOAD: begin
                        // Present Rsrc address now; data returns next cycle.
                        bus.addr_sel = 1'b1;
                        w_next       = S_LOADWB;
                    end
                    I_JAL: begin
`ifdef CTRL_JAL_EN
                        bus.reg_we  = 1'b1;
                        bus.wb_sel  = c_WB_PC1;
                        bus.pc_en   = 1'b1;
                        bus.pc_jump = 1'b1;
`else
                        bus.pc_en   = 1'b1;
`endif
                    end
                    default: begin
                        bus.reg_we = 1'b1;
                        bus.wb_sel = c_WB_ALU;
                        bus.pc_en  = 1'b1;
                        bus.psr_we = ~is_move(w_instr);
                    end
                endcase
            end
            S_LOADWB: begin
                bus.reg_we = 1'b1;
                bus.wb_sel = c_WB_MEM;
                bus.pc_en  = 1'b1;
                w_next     = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign bus.ir      = r_ir;
    assign bus.state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_cpu_controller.sv
// ============================================================================
// Module   : tb_cpu_controller
// Purpose  : Directed self-checking bench for cpu_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_controller;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    cpu_controller_if #(.DATA_W(16)) bus ();

    cpu_controller #(.DATA_W(16), .ADDR_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, pc_branch, pc_jump, addr_sel, mem_we, reg_we, wb_sel[1:0], psr_we}
    localparam logic [8:0] c_IDLE   = 9'b0_0_0_0_0_0_00_0;
    localparam logic [8:0] c_ALU    = 9'b1_0_0_0_0_1_00_1;
    localparam logic [8:0] c_MOVE   = 9'b1_0_0_0_0_1_00_0;
    localparam logic [8:0] c_PCONLY = 9'b1_0_0_0_0_0_00_0;
    localparam logic [8:0] c_BR     = 9'b1_1_0_0_0_0_00_0;
    localparam logic [8:0] c_JMP    = 9'b1_0_1_0_0_0_00_0;
    localparam logic [8:0] c_LDEX   = 9'b0_0_0_1_0_0_00_0;
    localparam logic [8:0] c_LDWB   = 9'b1_0_0_0_0_1_01_0;
    localparam logic [8:0] c_STOR   = 9'b1_0_0_1_1_0_00_0;
    localparam logic [8:0] c_JAL    = 9'b1_0_1_0_0_1_10_0;

    function automatic logic [8:0] strobes();
        return {bus.pc_en, bus.pc_branch, bus.pc_jump, bus.addr_sel,
                bus.mem_we, bus.reg_we, bus.wb_sel, bus.psr_we};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From S_FETCH, present instr and step to S_EXEC.
    task automatic to_exec(input string tag, input logic [15:0] instr, input logic [4:0] fl);
        bus.mem_dout = instr;
        bus.flags    = fl;
        tick();
        check({tag, " decode state"}, 32'(bus.state_o), 32'd1);
        tick();
        check({tag, " exec state"}, 32'(bus.state_o), 32'd2);
        check({tag, " ir"}, 32'(bus.ir), 32'(instr));
    endtask

    initial begin
        int n_mem_we;
        int n_reg_we;
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.mem_dout  = 16'h0000;
        bus.flags     = 5'b00000;
        #12;
        check("reset state", 32'(bus.state_o), 32'd0);
        check("reset ir", 32'(bus.ir), 32'd0);
        check("reset strobes", 32'(strobes()), 32'(c_IDLE));
        tick();
        reset = 1'b0;
        check("first fetch strobes", 32'(strobes()), 32'(c_IDLE));

        // ADD: 0,1,2,0
        to_exec("add", 16'h0531, 5'b00000);
        check("add strobes", 32'(strobes()), 32'(c_ALU));
        tick();
        check("add back to fetch", 32'(bus.state_o), 32'd0);
        check("fetch strobes", 32'(strobes()), 32'(c_IDLE));
        check("ir held in fetch", 32'(bus.ir), 32'h0531);

        // MOVI: register write without flag update
        to_exec("movi", 16'hD105, 5'b00000);
        check("movi strobes", 32'(strobes()), 32'(c_MOVE));
        tick();

        // BEQ -2, Z=1 then Z=0
        to_exec("beq z1", 16'hC0FE, 5'b00010);
        check("beq z1 strobes", 32'(strobes()), 32'(c_BR));
        tick();
        to_exec("beq z0", 16'hC0FE, 5'b00000);
        check("beq z0 strobes", 32'(strobes()), 32'(c_PCONLY));
        // flags are combinational in EXEC
        bus.flags = 5'b00010;
        #1;
        check("beq flag comb", 32'(bus.pc_branch), 32'd1);
        tick();

        // BLT with N=0,Z=0 taken; BGT with N=1 taken; BHS with C only not taken
        to_exec("blt", 16'hCC05, 5'b00000);
        check("blt strobes", 32'(strobes()), 32'(c_BR));
        tick();
        to_exec("bgt", 16'hC605, 5'b00001);
        check("bgt strobes", 32'(strobes()), 32'(c_BR));
        tick();
        to_exec("bhs", 16'hCB05, 5'b10000);
        check("bhs strobes", 32'(strobes()), 32'(c_PCONLY));
        tick();

        // LOAD R2,(R5): 4 cycles
        to_exec("load", 16'h4205, 5'b00000);
        check("load exec strobes", 32'(strobes()), 32'(c_LDEX));
        tick();
        check("load wb state", 32'(bus.state_o), 32'd3);
        check("load wb strobes", 32'(strobes()), 32'(c_LDWB));
        tick();
        check("load back to fetch", 32'(bus.state_o), 32'd0);

        // STOR: exactly one mem_we, no reg_we over the instruction
        n_mem_we = 0;
        n_reg_we = 0;
        bus.mem_dout = 16'h4345;
        for (int i = 0; i < 3; i++) begin
            n_mem_we += int'(bus.mem_we);
            n_reg_we += int'(bus.reg_we);
            if (bus.state_o == 3'd2) begin
                check("stor exec strobes", 32'(strobes()), 32'(c_STOR));
            end
            tick();
        end
        check("stor mem_we count", 32'(n_mem_we), 32'd1);
        check("stor reg_we count", 32'(n_reg_we), 32'd0);
        check("stor back to fetch", 32'(bus.state_o), 32'd0);

        // JUC R7, then never-condition
        to_exec("juc", 16'h4EC7, 5'b00000);
        check("juc strobes", 32'(strobes()), 32'(c_JMP));
        tick();
        to_exec("jnever", 16'h4FC7, 5'b11111);
        check("jnever strobes", 32'(strobes()), 32'(c_PCONLY));
        tick();

        // JAL
        to_exec("jal", 16'h4E87, 5'b00000);
`ifdef CTRL_JAL_EN
        check("jal strobes", 32'(strobes()), 32'(c_JAL));
`else
        check("jal nop strobes", 32'(strobes()), 32'(c_PCONLY));
`endif
        tick();

        // Reset mid-STOR aborts immediately
        to_exec("stor abort", 16'h4345, 5'b00000);
        check("stor abort pre mem_we", 32'(bus.mem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("abort mem_we", 32'(bus.mem_we), 32'd0);
        check("abort state", 32'(bus.state_o), 32'd0);
        check("abort ir", 32'(bus.ir), 32'd0);
        check("abort strobes", 32'(strobes()), 32'(c_IDLE));
        tick();
        check("held in reset strobes", 32'(strobes()), 32'(c_IDLE));
        reset = 1'b0;
        check("post reset fetch", 32'(bus.state_o), 32'd0);
        to_exec("resume add", 16'h0531, 5'b00000);
        check("resume add strobes", 32'(strobes()), 32'(c_ALU));
        tick();
        check("resume back to fetch", 32'(bus.state_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_controller.md
# cpu_controller

Multicycle sequencing FSM for the 16-bit CPU core. It drives the program counter's enable and branch/jump selects, latches the instruction register from program memory, and issues register-file, flag and memory strobes for each instruction. It sits between the unified instruction/data memory, the PC, the register file and the ALU. Every instruction takes 3 cycles, or 4 cycles for LOAD.

## Interface
Parameters:
- DATA_W, 16, instruction/data word width
- ADDR_W, 10, memory/PC address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- mem_dout  in  DATA_W  synchronous memory read data, valid the cycle after the address is presented
- flags  in  5  {C,L,F,Z,N} from the PSR
- ir  out  DATA_W  latched instruction
- pc_en  out  1  PC advances this cycle
- pc_branch  out  1  PC target = PC + sign-extended ir[7:0]
- pc_jump  out  1  PC target = register Rsrc; has priority over pc_branch
- addr_sel  out  1  0 = memory address from PC, 1 = from Rsrc
- mem_we  out  1  memory write strobe
- reg_we  out  1  register-file write to ir[11:8]
- wb_sel  out  2  write-back source: 0 ALU, 1 memory, 2 PC+1
- psr_we  out  1  flag register update
- state_o  out  3  current FSM state, for debug

## Operation
- Decode fields: op = ir[15:12], rdest/cond = ir[11:8], opext = ir[7:4], rsrc = ir[3:0].
- Bcond: op=1100. Jcond: op=0100 with opext=1100. LOAD: op=0100 with opext=0000. STOR: op=0100 with opext=0100. JAL: op=0100 with opext=1000. Every other encoding is an ALU op.
- FSM states: S_FETCH=0, S_DECODE=1, S_EXEC=2, S_LOADWB=3.
- S_FETCH: addr_sel=0; all strobes 0. Next state S_DECODE.
- S_DECODE: IR <= mem_dout at the clock edge. Next state S_EXEC.
- S_EXEC, ALU op: reg_we=1, wb_sel=0, pc_en=1. psr_we=1 for ALU ops only (never for CMP-free moves: op=1101 MOVI and opext=1101 MOV give psr_we=0). Next S_FETCH.
- S_EXEC, Bcond: pc_en=1, pc_branch=cond_true. Next S_FETCH.
- S_EXEC, Jcond: pc_en=1, pc_jump=cond_true. Next S_FETCH.
- S_EXEC, STOR: addr_sel=1, mem_we=1, pc_en=1. Next S_FETCH.
- S_EXEC, LOAD: addr_sel=1; no strobes. Next S_LOADWB.
- S_LOADWB: reg_we=1, wb_sel=1, pc_en=1. Next S_FETCH.
- Condition codes, on cond = ir[11:8]:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - HI 0100: L
  - LS 0101: !L
  - GT 0110: N
  - LE 0111: !N
  - FS 1000: F
  - FC 1001: !F
  - LO 1010: !L&!Z
  - HS 1011: L|Z
  - LT 1100: !N&!Z
  - GE 1101: N|Z
  - UC 1110: 1
  - 1111: 0
- Displacement is two's complement, 8-bit, sign-extended to ADDR_W by the PC datapath; the controller only selects.
- State 3-bit encoding: unused codes 4-7 return to S_FETCH on the next edge with all strobes 0.

## Timing
- Reset (async, any state): state=S_FETCH, ir=0. All strobes are 0 and addr_sel=0 while reset is asserted and in the first S_FETCH cycle after release.
- Reset asserted mid-instruction aborts it. No mem_we or reg_we is issued in the reset cycle; the PC keeps its value.
- Latency: ALU/branch/jump/store take 3 clocks FETCH-to-FETCH; LOAD takes 4.
- IR is stable from the edge ending S_DECODE until the next S_DECODE edge.
- Flags are sampled combinationally in S_EXEC. A flag update in an instruction's S_EXEC is visible to the next instruction.
- mem_we and reg_we are single-cycle pulses and are never asserted in the same cycle.

## Configuration
- CTRL_JAL_EN defined: JAL in S_EXEC gives reg_we=1, wb_sel=2 (link = PC+1), pc_en=1, pc_jump=1 unconditionally. The link write and the jump take effect on the same edge.
- CTRL_JAL_EN undefined: JAL decodes as a NOP, giving pc_en=1 with all other strobes 0, and wb_sel is never 2.

## Structure
- Shared package cpu_pkg: state encodings, opcode/opext constants, condition-code constants, wb_sel encodings.
- Sub-module cond_eval: combinational (cond[3:0], flags[4:0]) -> taken. Instantiated once.
- The FSM, IR register and strobe decode live in cpu_controller.

## Test plan
- Reset then ADD (mem_dout=16'h0531): state sequence 0,1,2,0. In S_EXEC: reg_we=1, psr_we=1, wb_sel=0, pc_en=1, ir=16'h0531.
- BEQ disp=-2 (16'hC0FE), Z=1 -> pc_branch=1 and pc_en=1 in S_EXEC. The same instruction with Z=0 -> pc_branch=0 and pc_en=1.
- LOAD R2,(R5) (16'h4205): addr_sel=1 in S_EXEC with no strobes. S_LOADWB gives reg_we=1, wb_sel=1, pc_en=1. Total 4 cycles.
- STOR (16'h4345): exactly one cycle with mem_we=1 and addr_sel=1; reg_we stays 0 throughout.
- JUC R7 (16'h4EC7): pc_jump=1. The same instruction with cond=1111 -> pc_jump=0 and pc_en=1. JAL 16'h4E87: pc_jump=1 and wb_sel=2 with CTRL_JAL_EN; all strobes 0 except pc_en without it.
- Assert reset during S_EXEC of a STOR: mem_we drops immediately, state=0, ir=0. Execution resumes cleanly from S_FETCH after release.
